// File: rtl/rhd_pkg.sv
// Shared constants, FSM state type and helpers for the RHD frame packer.
package rhd_pkg;

    localparam int NUM_STREAMS    = 32;
    localparam int CMDS_PER_FRAME = 35;
    localparam int SAMPLES        = NUM_STREAMS * CMDS_PER_FRAME;   // 1120
    localparam int FRAME_WORDS    = 2 + SAMPLES / 2;                // 562
    localparam int FIFO_AW        = 11;
    localparam int CNT_W          = 11;

    localparam logic [31:0]      MAGIC         = 32'hD7A22AAA;
    localparam logic [CNT_W-1:0] SAMPLES_W     = CNT_W'(SAMPLES);
    localparam logic [FIFO_AW:0] FRAME_WORDS_W = (FIFO_AW + 1)'(FRAME_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_COLLECT,
        ST_COMMIT,
        ST_DROP
    } state_t;

    // Saturating add of a small increment to a 16-bit statistics counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/rhd_commit_fifo.sv
// Single-clock BRAM FIFO with speculative/committed write pointers.
// Writes land behind a speculative pointer; the reader only sees words up to
// the committed pointer. rollback discards everything written since the last
// commit. The read side is a RAM output register (prefetch) followed by the
// stream output register, which gives one word per cycle while rd_ready=1.
module rhd_commit_fifo
    import rhd_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    input  logic          rollback,
    output logic [AW:0]   free,
    output logic [AW:0]   free_rb,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:(1 << AW) - 1];
    logic [AW:0]   wr_spec;
    logic [AW:0]   wr_cmt;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] pre_data;
    logic          pre_vld;
    logic          avail;
    logic          out_load;
    logic          rd_en;

    // Read scheduling: refill the prefetch register whenever it is empty or moving forward.
    always_comb begin
        avail    = (rd_ptr != wr_cmt);
        out_load = pre_vld && (!rd_valid || rd_ready);
        rd_en    = avail && (!pre_vld || out_load);
        free     = DEPTH - (wr_spec - rd_ptr);
        free_rb  = DEPTH - (wr_cmt - rd_ptr);
    end

    // RAM write port; a rolled-back cycle never advances the pointer, so the write is moot.
    always_ff @(posedge clk) begin
        if (wr_en && !rollback)
            mem[wr_spec[AW-1:0]] <= wr_data;
    end

    // RAM read port (output register); validity is tracked by pre_vld, which is reset.
    always_ff @(posedge clk) begin
        if (rd_en)
            pre_data <= mem[rd_ptr[AW-1:0]];
    end

    // Pointer bookkeeping; rollback restores the speculative pointer to the committed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_spec <= '0;
            wr_cmt  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rollback)
                wr_spec <= wr_cmt;
            else if (wr_en)
                wr_spec <= wr_spec + 1'b1;
            if (commit)
                wr_cmt <= wr_spec;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Prefetch valid and stream output register; output held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_vld  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            pre_vld <= rd_en || (pre_vld && !out_load);
            if (out_load) begin
                rd_data  <= pre_data;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rhd_frame_packer.sv
// Builds framed 32-bit packets from RHD sample words; incomplete frames are
// rolled back inside the FIFO and never reach the stream output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for in_frame_start
// ST_HDR0    | writing MAGIC speculatively
// ST_HDR1    | writing the frame timestamp; first sample may arrive
// ST_COLLECT | pairing samples into words
// ST_COMMIT  | publishing the completed frame to the read side
// ST_DROP    | no room at frame start; discarding until in_frame_end
module rhd_frame_packer
    import rhd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_frame_start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_frame_end,
    input  logic        clear_stats,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [15:0] frames_dropped,
    output logic        proto_err
);

    state_t             state;
    logic [31:0]        frame_cnt;
    logic [31:0]        ts;
    logic [15:0]        pair_lo;
    logic [CNT_W-1:0]   smp_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               start_d;
    logic               in_frame;
    logic               collecting;
    logic               viol;
    logic               take_smp;
    logic               over_smp;
    logic               end_ok;
    logic               fail_end;
    logic               abort;
    logic               rollback;
    logic               commit;
    logic               start_ok;
    logic [1:0]         drop_inc;
    logic [FIFO_AW:0]   free;
    logic [FIFO_AW:0]   free_rb;
    logic               wr_en;
    logic [32:0]        wr_data;
    logic [32:0]        rd_word;

    // Frame event decode: sample acceptance, end evaluation, abort and space check.
    always_comb begin
        in_frame   = (state == ST_HDR0) || (state == ST_HDR1) || (state == ST_COLLECT);
        collecting = (state == ST_HDR1) || (state == ST_COLLECT);
        viol       = in_valid && (in_frame_start || start_d);
        take_smp   = in_valid && !viol && collecting && (smp_cnt < SAMPLES_W);
        over_smp   = in_valid && !viol && collecting && (smp_cnt >= SAMPLES_W);
        if (take_smp)
            cnt_nxt = smp_cnt + 1'b1;
        else if (over_smp)
            cnt_nxt = SAMPLES_W + 1'b1;
        else
            cnt_nxt = smp_cnt;
        end_ok   = collecting && in_frame_end && !in_frame_start && (cnt_nxt == SAMPLES_W);
        abort    = in_frame && in_frame_start;
        fail_end = in_frame && in_frame_end && !in_frame_start && !end_ok;
        rollback = abort || fail_end;
        commit   = (state == ST_COMMIT);
        // An aborted frame frees its reserved space in the same cycle.
        start_ok = in_frame_start && ((in_frame ? free_rb : free) >= FRAME_WORDS_W);
        drop_inc = {1'b0, in_frame_start && !start_ok} + {1'b0, rollback};
    end

    // FIFO write port: headers, then one word per completed sample pair.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (!in_frame_start) begin
            case (state)
                ST_HDR0: begin
                    wr_en   = 1'b1;
                    wr_data = {1'b0, MAGIC};
                end
                ST_HDR1: begin
                    wr_en   = 1'b1;
                    wr_data = {1'b0, ts};
                end
                ST_COLLECT: begin
                    if (take_smp && smp_cnt[0]) begin
                        wr_en   = 1'b1;
                        wr_data = {(smp_cnt == SAMPLES_W - 1'b1), in_data, pair_lo};
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame FSM with sample counter, frame counter and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            frame_cnt      <= '0;
            ts             <= '0;
            pair_lo        <= '0;
            smp_cnt        <= '0;
            start_d        <= 1'b0;
            frames_dropped <= '0;
            proto_err      <= 1'b0;
        end else begin
            start_d <= in_frame_start;
            smp_cnt <= cnt_nxt;
            if (take_smp && !smp_cnt[0])
                pair_lo <= in_data;

            if (in_frame_start) begin
                frame_cnt <= frame_cnt + 1'b1;
                ts        <= frame_cnt;
                smp_cnt   <= '0;
                state     <= start_ok ? ST_HDR0 : ST_DROP;
            end else begin
                case (state)
                    ST_IDLE:    state <= ST_IDLE;
                    ST_HDR0:    state <= fail_end ? ST_IDLE : ST_HDR1;
                    ST_HDR1, ST_COLLECT: begin
                        if (end_ok)
                            state <= ST_COMMIT;
                        else if (fail_end)
                            state <= ST_IDLE;
                        else
                            state <= ST_COLLECT;
                    end
                    ST_COMMIT:  state <= ST_IDLE;
                    ST_DROP:    if (in_frame_end) state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end

            if (clear_stats) begin
                frames_dropped <= '0;
                proto_err      <= 1'b0;
            end else begin
                frames_dropped <= sat_add16(frames_dropped, drop_inc);
                if (viol || rollback)
                    proto_err <= 1'b1;
            end
        end
    end

    rhd_commit_fifo #(
        .AW (FIFO_AW),
        .DW (33)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .commit   (commit),
        .rollback (rollback),
        .free     (free),
        .free_rb  (free_rb),
        .rd_data  (rd_word),
        .rd_valid (m_tvalid),
        .rd_ready (m_tready)
    );

    assign m_tdata = rd_word[31:0];
    assign m_tlast = rd_word[32];

endmodule

// File: tb/tb_rhd_frame_packer.sv
// Directed bench for rhd_frame_packer with a word scoreboard on the output.
module tb_rhd_frame_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_frame_end = 1'b0;
    logic        clear_stats = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [15:0] frames_dropped;
    logic        proto_err;

    int vectors = 0;
    int miscompares = 0;

    logic [32:0] sb[$];
    logic [32:0] exp_word;
    logic        ready_level = 1'b0;
    logic        rand_mode = 1'b0;

    logic        p_stall = 1'b0;
    logic        p_hs_mid = 1'b0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;

    rhd_frame_packer dut (
        .clk            (clk),
        .rst            (rst),
        .in_frame_start (in_frame_start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_frame_end   (in_frame_end),
        .clear_stats    (clear_stats),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .frames_dropped (frames_dropped),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    // Downstream ready: either a fixed level or a 50% coin flip per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // Output monitor: scoreboard compare, stall stability and bubble checks.
    always @(negedge clk) begin
        if (rst) begin
            p_stall  = 1'b0;
            p_hs_mid = 1'b0;
        end else begin
            if (p_stall) begin
                vectors++;
                assert (m_tvalid === 1'b1 && m_tdata === p_data && m_tlast === p_last)
                else begin
                    miscompares++;
                    $error("FAIL stall_hold: observed v=%b d=%h l=%b expected v=1 d=%h l=%b",
                           m_tvalid, m_tdata, m_tlast, p_data, p_last);
                end
            end
            if (p_hs_mid) begin
                vectors++;
                assert (m_tvalid === 1'b1)
                else begin
                    miscompares++;
                    $error("FAIL no_bubble: observed m_tvalid=%b expected 1", m_tvalid);
                end
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                vectors++;
                assert (sb.size() != 0)
                else begin
                    miscompares++;
                    $error("FAIL unexpected_word: observed %h with empty scoreboard, expected no word", m_tdata);
                end
                if (sb.size() != 0) begin
                    exp_word = sb.pop_front();
                    vectors++;
                    assert ({m_tlast, m_tdata} === exp_word)
                    else begin
                        miscompares++;
                        $error("FAIL word: observed last=%b data=%h expected last=%b data=%h",
                               m_tlast, m_tdata, exp_word[32], exp_word[31:0]);
                    end
                end
            end
            p_stall  = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
            p_data   = m_tdata;
            p_last   = m_tlast;
            p_hs_mid = (m_tvalid === 1'b1) && (m_tready === 1'b1) && (m_tlast !== 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [31:0] ts, input logic [15:0] seed);
        logic [15:0] lo;
        logic [15:0] hi;
        sb.push_back({1'b0, 32'hD7A22AAA});
        sb.push_back({1'b0, ts});
        for (int k = 0; k < 560; k++) begin
            lo = seed + 16'(2 * k);
            hi = seed + 16'(2 * k + 1);
            sb.push_back({(k == 559), hi, lo});
        end
    endfunction

    task automatic send_frame(input int nsamp, input logic [15:0] seed, input int stop_at,
                              input bit end_on_last, input bit gaps);
        @(posedge clk); #1;
        in_frame_start = 1'b1;
        @(posedge clk); #1;
        in_frame_start = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < nsamp; i++) begin
            if (stop_at >= 0 && i == stop_at) begin
                in_valid = 1'b0;
                return;
            end
            if (gaps && $urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = seed + 16'(i);
            if (end_on_last && i == nsamp - 1)
                in_frame_end = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!end_on_last) begin
            in_frame_end = 1'b1;
            @(posedge clk); #1;
        end
        in_frame_end = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        vectors++;
        assert (sb.size() == 0)
        else begin
            miscompares++;
            $error("FAIL %s_drain: observed %0d words outstanding expected 0", tag, sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rand_mode = 1'b0;
        ready_level = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_dropped", 32'(frames_dropped), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single frame, samples 0..1119, ready held high
        ready_level = 1'b1;
        push_frame(32'd0, 16'd0);
        send_frame(1120, 16'd0, -1, 1'b0, 1'b0);
        wait_drain("single", 2000);
        @(negedge clk);
        chk("single_tvalid_idle", 32'(m_tvalid), 32'd0);
        chk("single_dropped", 32'(frames_dropped), 32'd0);
        chk("single_proto_err", 32'(proto_err), 32'd0);

        // Three frames fill the FIFO while stalled, the fourth is dropped
        do_reset();
        push_frame(32'd0, 16'h1000);
        send_frame(1120, 16'h1000, -1, 1'b1, 1'b0);
        push_frame(32'd1, 16'h2000);
        send_frame(1120, 16'h2000, -1, 1'b0, 1'b0);
        push_frame(32'd2, 16'h3000);
        send_frame(1120, 16'h3000, -1, 1'b1, 1'b0);
        send_frame(1120, 16'h4000, -1, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_dropped", 32'(frames_dropped), 32'd1);
        chk("full_proto_err", 32'(proto_err), 32'd0);
        chk("full_tvalid_stalled", 32'(m_tvalid), 32'd1);
        ready_level = 1'b1;
        wait_drain("full", 2500);
        push_frame(32'd4, 16'h5000);
        send_frame(1120, 16'h5000, -1, 1'b0, 1'b0);
        wait_drain("after_full", 2000);

        // Short and long frames are rolled back; stats then cleared
        do_reset();
        ready_level = 1'b1;
        send_frame(1119, 16'h0100, -1, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("short_proto_err", 32'(proto_err), 32'd1);
        chk("short_dropped", 32'(frames_dropped), 32'd1);
        chk("short_no_output", 32'(m_tvalid), 32'd0);
        send_frame(1121, 16'h0200, -1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("long_dropped", 32'(frames_dropped), 32'd2);
        push_frame(32'd2, 16'h0300);
        send_frame(1120, 16'h0300, -1, 1'b1, 1'b0);
        wait_drain("after_bad", 2000);
        @(posedge clk); #1;
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        @(negedge clk);
        chk("clear_dropped", 32'(frames_dropped), 32'd0);
        chk("clear_proto_err", 32'(proto_err), 32'd0);

        // New frame start in the middle of a frame aborts the first one
        do_reset();
        ready_level = 1'b1;
        send_frame(1120, 16'h0A00, 500, 1'b0, 1'b0);
        push_frame(32'd1, 16'h0B00);
        send_frame(1120, 16'h0B00, -1, 1'b0, 1'b0);
        wait_drain("abort", 2000);
        @(negedge clk);
        chk("abort_proto_err", 32'(proto_err), 32'd1);
        chk("abort_dropped", 32'(frames_dropped), 32'd1);

        // Reset while frame 1 is half read and frame 2 is being collected
        do_reset();
        push_frame(32'd0, 16'h7000);
        send_frame(1120, 16'h7000, -1, 1'b0, 1'b0);
        ready_level = 1'b1;
        repeat (283) @(posedge clk);
        ready_level = 1'b0;
        repeat (3) @(posedge clk);
        send_frame(1120, 16'h8000, 600, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        ready_level = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("midrst_idle", 32'(m_tvalid), 32'd0);
        chk("midrst_proto_err", 32'(proto_err), 32'd0);
        push_frame(32'd0, 16'h9000);
        send_frame(1120, 16'h9000, -1, 1'b1, 1'b0);
        wait_drain("midrst", 2000);

        // Random ready over ten frames with random input gaps
        do_reset();
        rand_mode = 1'b1;
        for (int f = 0; f < 10; f++) begin
            push_frame(32'(f), 16'(f * 16'h1111));
            send_frame(1120, 16'(f * 16'h1111), -1, 1'(f % 2), 1'b1);
        end
        wait_drain("random", 6000);
        @(negedge clk);
        chk("random_dropped", 32'(frames_dropped), 32'd0);
        chk("random_proto_err", 32'(proto_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
